// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the CPU-to-memory bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_ACC   = 2'd1,
    I_ACC   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/bus_arb_lane.sv
// Byte-lane steering: request decode (enables, write replication, legality)
// and read-data alignment for the latched response.
module bus_arb_lane
  import bus_arb_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [2:0]  req_len,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad,
  input  logic [1:0]  rsp_off,
  input  logic [2:0]  rsp_len,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Exactly one of read/write must be requested, with a legal aligned size.
  always_comb begin
    be    = 4'b0000;
    wdata = req_wdata;
    bad   = (req_rd == req_wr);
    case (req_len)
      LEN_B: begin
        be    = 4'b0001 << req_off;
        wdata = {4{req_wdata[7:0]}};
      end
      LEN_H: begin
        be    = 4'b0011 << {req_off[1], 1'b0};
        wdata = {2{req_wdata[15:0]}};
        bad   = bad | req_off[0];
      end
      LEN_W: begin
        be  = 4'b1111;
        bad = bad | (req_off != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    shifted = rsp_rdata >> {rsp_off, 3'b000};
    case (rsp_len)
      LEN_B:   rdata = {24'h0, shifted[7:0]};
      LEN_H:   rdata = {16'h0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-port memory arbiter: per instruction, optional data phase then fetch.
// Watchdog per memory phase is built only when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] IADDR,
  output logic [31:0] IDATA,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  input  logic        DRD,
  input  logic        DWR,
  input  logic        DAS,
  output logic [31:0] DATAI,
  output logic        BERR,
  output logic        HLT,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err
);

  state_t      state, state_nxt;
  logic        err_q, err_nxt;
  logic [29:0] fetch_word, fetch_word_nxt;
  logic [1:0]  rd_off, rd_off_nxt;
  logic [2:0]  rd_len, rd_len_nxt;
  logic [31:0] idata_nxt, datai_nxt, addr_nxt, wdata_nxt;
  logic        req_nxt, we_nxt, hlt_nxt, berr_nxt;
  logic [3:0]  be_nxt;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_bad;
  logic        wd_hit;
  logic        unused_iaddr;

  assign unused_iaddr = ^IADDR[1:0];

  bus_arb_lane u_lane (
    .req_off   (DADDR[1:0]),
    .req_len   (DLEN),
    .req_rd    (DRD),
    .req_wr    (DWR),
    .req_wdata (DATAO),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .bad       (lane_bad),
    .rsp_off   (rd_off),
    .rsp_len   (rd_len),
    .rsp_rdata (mem_rdata),
    .rdata     (lane_rdata)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT-th consecutive cycle of a phase without ack.
  assign wd_hit = !mem_ack && ((32'(wd_cnt) + 32'd1) == 32'(TIMEOUT));

  always_ff @(posedge CLK) begin
    if (RES || (state_nxt != state)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    err_nxt        = err_q;
    fetch_word_nxt = fetch_word;
    rd_off_nxt     = rd_off;
    rd_len_nxt     = rd_len;
    idata_nxt      = IDATA;
    datai_nxt      = DATAI;
    req_nxt        = mem_req;
    we_nxt         = mem_we;
    be_nxt         = mem_be;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    case (state)
      IDLE: begin
        fetch_word_nxt = IADDR[31:2];
        rd_off_nxt     = DADDR[1:0];
        rd_len_nxt     = DLEN;
        req_nxt        = 1'b1;
        if (DAS && !lane_bad) begin
          state_nxt = D_ACC;
          we_nxt    = DWR;
          be_nxt    = lane_be;
          addr_nxt  = {DADDR[31:2], 2'b00};
          wdata_nxt = lane_wdata;
        end else begin
          // A rejected data request still lets the fetch proceed.
          state_nxt = I_ACC;
          err_nxt   = DAS & lane_bad;
          we_nxt    = 1'b0;
          be_nxt    = 4'b1111;
          addr_nxt  = {IADDR[31:2], 2'b00};
        end
      end
      D_ACC: begin
        if (mem_ack || wd_hit) begin
          if (!mem_we) begin
            datai_nxt = (mem_ack && !mem_err) ? lane_rdata : 32'h0;
          end
          err_nxt   = err_q | wd_hit | (mem_ack & mem_err);
          state_nxt = I_ACC;
          we_nxt    = 1'b0;
          be_nxt    = 4'b1111;
          addr_nxt  = {fetch_word, 2'b00};
        end
      end
      I_ACC: begin
        if (mem_ack || wd_hit) begin
          idata_nxt = (mem_ack && !mem_err) ? mem_rdata : 32'h0;
          err_nxt   = err_q | wd_hit | (mem_ack & mem_err);
          state_nxt = RELEASE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          be_nxt    = 4'b0000;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        err_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    hlt_nxt  = (state_nxt != RELEASE);
    berr_nxt = (state_nxt == RELEASE) && err_nxt;
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge CLK) begin
    if (RES) begin
      err_q      <= 1'b0;
      fetch_word <= '0;
      rd_off     <= '0;
      rd_len     <= '0;
      IDATA      <= '0;
      DATAI      <= '0;
      BERR       <= 1'b0;
      HLT        <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      err_q      <= err_nxt;
      fetch_word <= fetch_word_nxt;
      rd_off     <= rd_off_nxt;
      rd_len     <= rd_len_nxt;
      IDATA      <= idata_nxt;
      DATAI      <= datai_nxt;
      BERR       <= berr_nxt;
      HLT        <= hlt_nxt;
      mem_req    <= req_nxt;
      mem_we     <= we_nxt;
      mem_be     <= be_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
    end
  end

endmodule
